lfsr_rr_sched: RTL and testbench

Round-robin scheduler that owns a 16-bit Galois LFSR and shares its output among NUM_REQ requesters over valid/ready handshakes. It sequences the generator through three phases: seed load, warm-up stepping, then on-demand service. The LFSR advances exactly once per word delivered, so no requester ever sees a duplicate or skipped word. It sits between the top-level pin wrapper and the consumers of pseudo-random data.

---
 rtl/lfsr_sched_pkg.sv | 16 +
 rtl/lfsr_galois_step.sv | 14 +
 rtl/lfsr_rr_sched.sv | 141 ++++++++++++++
 tb/tb_lfsr_rr_sched.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_sched_pkg.sv
// Shared types and constants for the LFSR round-robin scheduler.
package lfsr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_SERVE  = 2'd2
  } state_e;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STATS_W = 16;

  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_RST     = 16'h0001;

endpackage

// File: rtl/lfsr_galois_step.sv
// One combinational step of a right-shifting Galois LFSR.
module lfsr_galois_step
  import lfsr_sched_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);

  assign next_o = (state_i >> 1) ^ (state_i[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler sharing one Galois LFSR among NUM_REQ requesters.
// Define LFSR_SCHED_STATS_EN to add the saturating served_cnt_o counter.
module lfsr_rr_sched
  import lfsr_sched_pkg::*;
#(
  parameter int unsigned      NUM_REQ = 4,
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(DEFAULT_TAPS),
  parameter int unsigned      WARMUP  = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               seed_valid_i,
  input  logic [WIDTH-1:0]   seed_i,
  output logic               seed_ready_o,
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  output logic [WIDTH-1:0]   rand_o,
  output logic               busy_o,
`ifdef LFSR_SCHED_STATS_EN
  output logic [STATS_W-1:0] served_cnt_o,
`endif
  output logic [1:0]         state_o
);

  localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WARM_LAST = (WARMUP == 0) ? 0 : WARMUP - 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d, lfsr_step;
  logic [PTR_W-1:0]   ptr_q, ptr_d, pick;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W:0]     scan_idx;
  logic [NUM_REQ-1:0] req_m, grant_c;
  logic               found, transfer, seed_ready_c, seed_acc;
  logic [WIDTH-1:0]   seed_fix;

  lfsr_galois_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
    .state_i (lfsr_q),
    .next_o  (lfsr_step)
  );

  // An all-zero seed would lock the LFSR at zero forever.
  assign seed_fix = (seed_i == '0) ? WIDTH'(LFSR_RST) : seed_i;

  // Round-robin pick starting at ptr_q; a pending seed suppresses all grants.
  always_comb begin
    req_m    = (state_q == ST_SERVE && !seed_valid_i) ? req_valid_i : '0;
    grant_c  = '0;
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (scan_idx >= (PTR_W+1)'(NUM_REQ)) scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
      if (!found && req_m[scan_idx[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = scan_idx[PTR_W-1:0];
      end
    end
    if (found) grant_c[pick] = 1'b1;
    transfer = found;
  end

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    seed_ready_c = 1'b0;
    seed_acc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        seed_ready_c = 1'b1;
        seed_acc     = seed_valid_i;
        if (seed_valid_i) begin
          lfsr_d  = seed_fix;
          cnt_d   = '0;
          state_d = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WARM_LAST)) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        seed_ready_c = 1'b1;
        seed_acc     = seed_valid_i;
        if (seed_valid_i) begin
          lfsr_d  = seed_fix;
          cnt_d   = '0;
          state_d = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;
        end else if (transfer) begin
          lfsr_d = lfsr_step;
          ptr_d  = ((PTR_W+1)'(pick) + (PTR_W+1)'(1) >= (PTR_W+1)'(NUM_REQ))
                   ? '0 : pick + PTR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      lfsr_q  <= WIDTH'(LFSR_RST);
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef LFSR_SCHED_STATS_EN
  logic [STATS_W-1:0] served_q;

  // Saturating count of delivered words since the last accepted seed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      served_q <= '0;
    end else if (seed_acc) begin
      served_q <= '0;
    end else if (transfer && served_q != '1) begin
      served_q <= served_q + STATS_W'(1);
    end
  end

  assign served_cnt_o = served_q;
`endif

  assign seed_ready_o = seed_ready_c;
  assign req_ready_o  = grant_c;
  assign rand_o       = lfsr_q;
  assign busy_o       = (state_q == ST_WARMUP);
  assign state_o      = state_q;

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Directed, table-driven bench for lfsr_rr_sched (WARMUP=2 and WARMUP=0 instances).
module tb_lfsr_rr_sched;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WARMUP = 2
  logic        rst_a, sv_a, srdy_a, busy_a;
  logic [15:0] seed_a, rand_a;
  logic [3:0]  req_a, rdy_a;
  logic [1:0]  st_a;
  // Instance B: WARMUP = 0
  logic        rst_b, sv_b, srdy_b, busy_b;
  logic [15:0] seed_b, rand_b;
  logic [3:0]  req_b, rdy_b;
  logic [1:0]  st_b;
`ifdef LFSR_SCHED_STATS_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  lfsr_rr_sched #(.NUM_REQ(4), .WIDTH(16), .TAPS(16'hB400), .WARMUP(2)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .seed_valid_i(sv_a), .seed_i(seed_a),
    .seed_ready_o(srdy_a), .req_valid_i(req_a), .req_ready_o(rdy_a),
    .rand_o(rand_a), .busy_o(busy_a),
`ifdef LFSR_SCHED_STATS_EN
    .served_cnt_o(cnt_a),
`endif
    .state_o(st_a)
  );

  lfsr_rr_sched #(.NUM_REQ(4), .WIDTH(16), .TAPS(16'hB400), .WARMUP(0)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .seed_valid_i(sv_b), .seed_i(seed_b),
    .seed_ready_o(srdy_b), .req_valid_i(req_b), .req_ready_o(rdy_b),
    .rand_o(rand_b), .busy_o(busy_b),
`ifdef LFSR_SCHED_STATS_EN
    .served_cnt_o(cnt_b),
`endif
    .state_o(st_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic        sv;
    logic [15:0] seed;
    logic [3:0]  exp_rdy;
    logic [15:0] exp_rand;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // SERVE entered with rand=5A00, pointer 0
    vecs[0]  = '{4'b0001, 1'b0, 16'h0000, 4'b0001, 16'h5A00};
    vecs[1]  = '{4'b0010, 1'b0, 16'h0000, 4'b0010, 16'h2D00};
    vecs[2]  = '{4'b0100, 1'b0, 16'h0000, 4'b0100, 16'h1680};
    vecs[3]  = '{4'b1000, 1'b0, 16'h0000, 4'b1000, 16'h0B40};
    vecs[4]  = '{4'b1111, 1'b0, 16'h0000, 4'b0001, 16'h05A0};
    vecs[5]  = '{4'b1111, 1'b0, 16'h0000, 4'b0010, 16'h02D0};
    vecs[6]  = '{4'b1111, 1'b0, 16'h0000, 4'b0100, 16'h0168};
    vecs[7]  = '{4'b1111, 1'b0, 16'h0000, 4'b1000, 16'h00B4};
    vecs[8]  = '{4'b1111, 1'b0, 16'h0000, 4'b0001, 16'h005A};
    vecs[9]  = '{4'b1111, 1'b0, 16'h0000, 4'b0010, 16'h002D};
    vecs[10] = '{4'b1111, 1'b0, 16'h0000, 4'b0100, 16'hB416};
    vecs[11] = '{4'b1111, 1'b0, 16'h0000, 4'b1000, 16'h5A0B};
    vecs[12] = '{4'b0000, 1'b0, 16'h0000, 4'b0000, 16'h9905};
    vecs[13] = '{4'b0100, 1'b0, 16'h0000, 4'b0100, 16'h9905};
    vecs[14] = '{4'b0100, 1'b0, 16'h0000, 4'b0100, 16'hF882};
    vecs[15] = '{4'b0100, 1'b1, 16'h1234, 4'b0000, 16'h7C41};

    rst_a = 1'b1; sv_a = 1'b0; seed_a = '0; req_a = '0;
    rst_b = 1'b1; sv_b = 1'b0; seed_b = '0; req_b = '0;
    tick();
    tick();
    chk("reset_state",      32'(st_a),   32'd0);
    chk("reset_rand",       32'(rand_a), 32'h0001);
    chk("reset_ready",      32'(rdy_a),  32'd0);
    chk("reset_seed_ready", 32'(srdy_a), 32'd1);
    chk("reset_busy",       32'(busy_a), 32'd0);

    // Seed load and two warm-up steps
    rst_a = 1'b0;
    sv_a = 1'b1; seed_a = 16'h0001;
    tick();
    sv_a = 1'b0; req_a = 4'b1111;
    #1;
    chk("warm_state",      32'(st_a),   32'd1);
    chk("warm_busy",       32'(busy_a), 32'd1);
    chk("warm_seed_ready", 32'(srdy_a), 32'd0);
    chk("warm_ready",      32'(rdy_a),  32'd0);
    tick();
    chk("warm_step1",      32'(rand_a), 32'hB400);
    chk("warm_state2",     32'(st_a),   32'd1);
    req_a = 4'b0000;
    tick();
    chk("serve_state",     32'(st_a),   32'd2);
    chk("serve_busy",      32'(busy_a), 32'd0);
    chk("serve_rand",      32'(rand_a), 32'h5A00);

    for (int i = 0; i < 16; i++) begin
      req_a = vecs[i].req; sv_a = vecs[i].sv; seed_a = vecs[i].seed;
      #1;
      chk($sformatf("vec%0d_grant", i), 32'(rdy_a),  32'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_rand", i),  32'(rand_a), 32'(vecs[i].exp_rand));
      chk($sformatf("vec%0d_srdy", i),  32'(srdy_a), 32'd1);
      tick();
    end

    // Collision: seed loaded unstepped, re-enter warm-up
    chk("collide_state", 32'(st_a),   32'd1);
    chk("collide_rand",  32'(rand_a), 32'h1234);
    sv_a = 1'b0; req_a = 4'b0000;
    tick();
    tick();
    chk("reseed_serve_state", 32'(st_a),   32'd2);
    chk("reseed_serve_rand",  32'(rand_a), 32'h048D);

    // Pointer preserved across reseed (last grant was 2), then async reset
    req_a = 4'b1111;
    #1;
    chk("ptr_kept_grant", 32'(rdy_a), 32'b1000);
    #2 rst_a = 1'b1;
    #1;
    chk("async_rst_state", 32'(st_a),   32'd0);
    chk("async_rst_rand",  32'(rand_a), 32'h0001);
    chk("async_rst_ready", 32'(rdy_a),  32'd0);
    @(negedge clk);
    rst_a = 1'b0; req_a = 4'b0000;

    // Zero seed with WARMUP=0 goes straight to SERVE with 0001
    rst_b = 1'b0;
    sv_b = 1'b1; seed_b = 16'h0000;
    tick();
    sv_b = 1'b0; req_b = 4'b0001;
    #1;
    chk("zero_seed_state", 32'(st_b),   32'd2);
    chk("zero_seed_rand",  32'(rand_b), 32'h0001);
    chk("zero_seed_busy",  32'(busy_b), 32'd0);
    chk("zero_seed_grant", 32'(rdy_b),  32'b0001);
    tick();
    req_b = 4'b0000;
    chk("zero_seed_step",  32'(rand_b), 32'hB400);

`ifdef LFSR_SCHED_STATS_EN
    sv_a = 1'b1; seed_a = 16'h0001;
    tick();
    sv_a = 1'b0;
    tick();
    tick();
    req_a = 4'b0001;
    repeat (5) tick();
    req_a = 4'b0000;
    chk("stats_five", 32'(cnt_a), 32'd5);
    sv_a = 1'b1;
    tick();
    sv_a = 1'b0;
    chk("stats_clear", 32'(cnt_a), 32'd0);
    tick();
    tick();
    req_a = 4'b1111;
    repeat (65540) tick();
    req_a = 4'b0000;
    chk("stats_saturate", 32'(cnt_a), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
